ha_ow_collector: RTL
====================

HA_OW_COLLECTOR -- requirements
Module: ha_ow_collector

Interface
REQ-001 Parameter DATA_BW, default 32, width of the data word.
REQ-002 Parameter DEPTH, default 4, number of buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  DATA_BW  word from the upstream output-wrapper stage.
REQ-006 in_valid  input  1  in_data holds a valid word this cycle.
REQ-007 in_ready  output  1  collector accepts a word this cycle.
REQ-008 out_data  output  DATA_BW  head-of-buffer word to the downstream consumer.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 overflow  output  1  sticky flag: a word was offered while the buffer was full.
REQ-013 clr_ovf  input  1  clears overflow.

Function
REQ-014 Write event: in_valid=1 and in_ready=1 in the same cycle; the block SHALL store in_data at the write pointer.
REQ-015 Read event: out_valid=1 and out_ready=1 in the same cycle; the block SHALL advance the read pointer.
REQ-016 in_ready SHALL be combinational: 1 when count<DEPTH and rst=0; 0 otherwise.
REQ-017 When full, in_ready SHALL stay 0 even if a read occurs that cycle; there is no full-state pass-through.
REQ-018 out_valid SHALL equal (count!=0).
REQ-019 out_data SHALL equal the entry at the read pointer when out_valid=1, and SHALL be all-zero when out_valid=0.
REQ-020 There is no bypass path: a word written into an empty buffer at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N (latency 1).
REQ-021 count SHALL update as follows: +1 on a write only; -1 on a read only; unchanged on a simultaneous write and read, or on neither.
REQ-022 Pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO across the wrap.
REQ-023 Words SHALL NOT be lost, duplicated, or altered; the held out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 in_valid=1 with in_ready=0 (rst=0) SHALL set overflow at the next edge; the offered word is discarded.
REQ-025 clr_ovf=1 SHALL clear overflow at the next edge; if a set condition occurs in the same cycle, the set SHALL win.
REQ-026 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL set the pointers to 0, count to 0 and overflow to 0; out_valid SHALL then be 0 and out_data all-zero.
REQ-028 Storage contents need no reset.
REQ-029 A reset asserted mid-operation SHALL discard all buffered words and any handshake in that cycle; in_ready SHALL be 0 while rst=1.
REQ-030 In the first cycle after rst deasserts, in_ready=1 and count=0.

Verification
REQ-031 Reset then write 0x11111111 with out_ready=0 -> next cycle out_valid=1, out_data=0x11111111, count=1.
REQ-032 Write 0xA0..0xA3 back-to-back with out_ready=0 -> count=4, in_ready=0; offer 0xA4 -> overflow=1, 0xA4 never appears at the output; then drain -> output is 0xA0,0xA1,0xA2,0xA3.
REQ-033 count=2, simultaneous write and read for 10 cycles -> count stays 2; the output sequence matches the input order across pointer wrap.
REQ-034 overflow=1, clr_ovf=1 in the same cycle as a full-buffer offer -> overflow stays 1; clr_ovf alone next cycle -> overflow=0.
REQ-035 count=3, assert rst for 1 cycle during a write -> afterwards count=0, out_valid=0, out_data=0, in_ready=1.
REQ-036 Random in_valid/out_ready (50% each, 1000 words) -> scoreboard shows exact in-order match, and overflow stays 0 whenever no offer was made while in_ready=0.

Source files
------------

// File: rtl/ha_ow_collector.sv
// Output-wrapper collector: a DEPTH-entry FIFO between the output-wrapper stage and its consumer,
// with a sticky overflow flag for words offered while full.
module ha_ow_collector #(
  parameter int DATA_BW = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BW-1:0]         in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_BW-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BW-1:0] mem_q [DEPTH];
  logic [DATA_BW-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               wr_en, rd_en;

  always_comb begin
    in_ready  = !rst && (count_q < CW'(DEPTH));
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    count     = count_q;
    overflow  = ovf_q;

    wr_en = in_valid && in_ready;
    rd_en = out_valid && out_ready && !rst;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A rejected offer takes priority over a clear in the same cycle.
    if (in_valid && !in_ready && !rst) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
